// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue between IF and ID. Buffers up to
//               DEPTH {instruction, pc} pairs in a circular buffer so IF can
//               keep fetching while ID is stalled; ID drains in push order.
//               A flush (taken branch / jump) empties the queue in one cycle.
// Ports       : clk, rst (sync, active-low)
//               in_valid / in_instruction / in_pc / in_ready   - IF side
//               stall_pipeline, flush                          - control
//               out_valid / out_instruction / out_pc           - ID side
//               count                                          - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [INST_WIDTH-1:0]    in_instruction,
    input  logic [PC_WIDTH-1:0]      in_pc,
    output logic                     in_ready,
    input  logic                     stall_pipeline,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [INST_WIDTH-1:0]    out_instruction,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [INST_WIDTH-1:0] r_mem_inst [DEPTH];
    logic [PC_WIDTH-1:0]   r_mem_pc   [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Readiness depends only on the registered count, so a pop while full
    // cannot open the door to a push in the same cycle.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    assign w_push = in_valid && !w_full && !flush;
    assign w_pop  = !w_empty && !stall_pipeline && !flush;

    // Head entry, forced to a NOP / zero pc while empty so ID sees a bubble.
    assign out_instruction = w_empty ? '0 : r_mem_inst[r_rd_ptr];
    assign out_pc          = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign count           = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; the zeroed count hides stale entries.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_inst[r_wr_ptr] <= in_instruction;
                r_mem_pc[r_wr_ptr]   <= in_pc;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            // Power-of-two DEPTH lets the pointers wrap naturally.
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (DEPTH=4). A table of
//               one-cycle vectors with hand-computed post-edge expectations,
//               plus hand-written sequences for flush, bypass and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 32;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [INST_WIDTH-1:0] in_instruction;
    logic [PC_WIDTH-1:0]   in_pc;
    logic                  in_ready;
    logic                  stall_pipeline;
    logic                  flush;
    logic                  out_valid;
    logic [INST_WIDTH-1:0] out_instruction;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [2:0]            count;

    fetch_queue #(
        .INST_WIDTH (INST_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .in_ready        (in_ready),
        .stall_pipeline  (stall_pipeline),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [31:0] pc;
        logic        stall;
        logic        fl;
        int          e_cnt;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_errors;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic void add(input logic r, input logic v, input logic [31:0] p,
                                input logic s, input logic f, input int c,
                                input logic rdy, input logic ov, input logic [31:0] ep);
        vec_t t;
        t.rst_n = r; t.vld = v; t.pc = p; t.stall = s; t.fl = f;
        t.e_cnt = c; t.e_rdy = rdy; t.e_ov = ov; t.e_pc = ep;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int c, input logic rdy,
                               input logic ov, input logic [31:0] ep);
        chk({tag, " count"},     32'(count),     32'(c));
        chk({tag, " in_ready"},  32'(in_ready),  32'(rdy));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " out_pc"},    out_pc,         ov ? ep : 32'h0);
        chk({tag, " out_inst"},  out_instruction, ov ? mk_inst(ep) : 32'h0);
    endtask

    // Drive inputs away from the edge, clock once, sample just after.
    task automatic cycle(input logic r, input logic v, input logic [31:0] p,
                         input logic s, input logic f);
        @(negedge clk);
        rst = r; in_valid = v; in_pc = p; in_instruction = mk_inst(p);
        stall_pipeline = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = '0;
        stall_pipeline = 1'b0; flush = 1'b0;

        // 1: reset held two cycles with in_valid high
        add(0, 1, 32'h99, 0, 0, 0, 1, 0, 0);
        add(0, 1, 32'h99, 0, 0, 0, 1, 0, 0);
        // 2: fill under stall, 5th push ignored, then drain in order
        add(1, 1, 32'h0, 1, 0, 1, 1, 1, 32'h0);
        add(1, 1, 32'h1, 1, 0, 2, 1, 1, 32'h0);
        add(1, 1, 32'h2, 1, 0, 3, 1, 1, 32'h0);
        add(1, 1, 32'h3, 1, 0, 4, 0, 1, 32'h0);
        add(1, 1, 32'h4, 1, 0, 4, 0, 1, 32'h0);
        add(1, 0, 32'h0, 0, 0, 3, 1, 1, 32'h1);
        add(1, 0, 32'h0, 0, 0, 2, 1, 1, 32'h2);
        add(1, 0, 32'h0, 0, 0, 1, 1, 1, 32'h3);
        add(1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        add(1, 0, 32'h0, 1, 0, 0, 1, 0, 32'h0);
        // 3: streaming pc 0..9 across pointer wrap, count stays 1
        for (int k = 0; k < 10; k++) add(1, 1, 32'(k), 0, 0, 1, 1, 1, 32'(k));
        add(1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
        // 5: full and pop together; push resumes only on the next edge
        add(1, 1, 32'h40, 1, 0, 1, 1, 1, 32'h40);
        add(1, 1, 32'h41, 1, 0, 2, 1, 1, 32'h40);
        add(1, 1, 32'h42, 1, 0, 3, 1, 1, 32'h40);
        add(1, 1, 32'h43, 1, 0, 4, 0, 1, 32'h40);
        add(1, 1, 32'h44, 0, 0, 3, 1, 1, 32'h41);
        add(1, 1, 32'h44, 1, 0, 4, 0, 1, 32'h41);
        add(1, 0, 32'h0, 0, 0, 3, 1, 1, 32'h42);
        add(1, 0, 32'h0, 0, 0, 2, 1, 1, 32'h43);
        add(1, 0, 32'h0, 0, 0, 1, 1, 1, 32'h44);
        add(1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].vld, vecs[i].pc, vecs[i].stall, vecs[i].fl);
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_rdy,
                        vecs[i].e_ov, vecs[i].e_pc);
        end

        // No same-cycle bypass: a push presented to an empty queue is not
        // visible before the edge.
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h10; in_instruction = mk_inst(32'h10);
        stall_pipeline = 1'b1; flush = 1'b0;
        #1;
        chk("bypass out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check_state("bypass after", 1, 1, 1, 32'h10);

        // 4: flush with three entries and a concurrent push of 0x20
        cycle(1, 1, 32'h11, 1, 0);
        cycle(1, 1, 32'h12, 1, 0);
        check_state("flush pre", 3, 1, 1, 32'h10);
        cycle(1, 1, 32'h20, 0, 1);
        check_state("flush post", 0, 1, 0, 32'h0);
        cycle(1, 1, 32'h30, 1, 0);
        check_state("flush push30", 1, 1, 1, 32'h30);
        cycle(1, 0, 32'h0, 0, 0);
        check_state("flush drain", 0, 1, 0, 32'h0);

        // 6: reset mid-operation overrides push; first push afterwards leads
        cycle(1, 1, 32'h50, 1, 0);
        cycle(1, 1, 32'h51, 1, 0);
        check_state("rst pre", 2, 1, 1, 32'h50);
        cycle(0, 1, 32'h52, 0, 1);
        check_state("rst post", 0, 1, 0, 32'h0);
        cycle(1, 1, 32'h60, 1, 0);
        check_state("rst push60", 1, 1, 1, 32'h60);
        cycle(1, 1, 32'h61, 0, 0);
        check_state("rst push61", 1, 1, 1, 32'h61);
        cycle(1, 0, 32'h0, 0, 0);
        check_state("rst drain", 0, 1, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
